mux8bit_arbiter: RTL and testbench

Two-requester round-robin arbiter that shares one 8-bit 2:1 data multiplexer (mux8bit) between requesters A and B. It drives the mux select, performs a req/ack handshake with each requester, and captures the selected byte into an output register. A valid/ready handshake drains that register to the downstream consumer. A hold limit bounds how long one requester may monopolise the path while the other waits.

---
 rtl/mux8bit_arbiter_pkg.sv | 18 +
 rtl/mux8bit_arbiter_mux8bit.sv | 13 +
 rtl/mux8bit_arbiter.sv | 120 ++++++++++++
 tb/tb_mux8bit_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mux8bit_arbiter_pkg.sv
// Shared constants for the two-requester byte arbiter: FSM encoding, owner ids
// and datapath/counter widths.
package mux8bit_arbiter_pkg;

    localparam int DATA_W = 8;
    localparam int HOLD_W = 8;
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } state_t;

endpackage

// File: rtl/mux8bit_arbiter_mux8bit.sv
// Byte-wide 2:1 multiplexer shared between the two requesters.
module mux8bit
    import mux8bit_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] f
);

    assign f = sel ? b : a;

endmodule

// File: rtl/mux8bit_arbiter.sv
// Round-robin arbiter with a per-owner hold limit that steers one shared byte
// mux and captures the winning byte into a valid/ready output register.
module mux8bit_arbiter
    import mux8bit_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 4
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_a,
    input  logic [DATA_W-1:0] data_a,
    output logic              ack_a,
    input  logic              req_b,
    input  logic [DATA_W-1:0] data_b,
    output logic              ack_b,
    output logic              sel,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_owner,
    input  logic              out_ready
);

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nxt;
    logic [HOLD_W-1:0] hold_cnt, hold_nxt;
    logic              last_owner, last_nxt;
    logic              space;
    logic              cur_owner;
    logic              req_own, req_oth, ack_own;
    logic [DATA_W-1:0] mux_f;

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] c);
        return (c == HOLD_SAT) ? c : c + 1'b1;
    endfunction

    function automatic state_t own_state(input logic o);
        return (o == OWNER_B) ? ST_OWN_B : ST_OWN_A;
    endfunction

    mux8bit u_mux (
        .a   (data_a),
        .b   (data_b),
        .sel (sel),
        .f   (mux_f)
    );

    assign space     = !out_valid || out_ready;
    assign ack_a     = (state == ST_OWN_A) && req_a && space;
    assign ack_b     = (state == ST_OWN_B) && req_b && space;
    assign sel       = (state == ST_OWN_B);

    // Current owner viewed generically so OWN_A/OWN_B share one transition body.
    assign cur_owner = sel ? OWNER_B : OWNER_A;
    assign req_own   = (cur_owner == OWNER_B) ? req_b : req_a;
    assign req_oth   = (cur_owner == OWNER_B) ? req_a : req_b;
    assign ack_own   = ack_a || ack_b;

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        last_nxt  = last_owner;
        case (state)
            ST_IDLE: begin
                if (req_a && req_b)
                    state_nxt = (last_owner == OWNER_B) ? ST_OWN_A : ST_OWN_B;
                else if (req_a)
                    state_nxt = ST_OWN_A;
                else if (req_b)
                    state_nxt = ST_OWN_B;
            end
            ST_OWN_A, ST_OWN_B: begin
                if (!req_own) begin
                    state_nxt = req_oth ? own_state(!cur_owner) : ST_IDLE;
                    hold_nxt  = '0;
                    last_nxt  = cur_owner;
                end else if (ack_own && req_oth && hold_cnt == HOLD_LAST) begin
                    state_nxt = own_state(!cur_owner);
                    hold_nxt  = '0;
                    last_nxt  = cur_owner;
                end else if (ack_own) begin
                    hold_nxt  = req_oth ? hold_inc(hold_cnt) : '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            hold_cnt   <= '0;
            last_owner <= OWNER_B;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            last_owner <= last_nxt;
        end
    end

    // Output register: a new capture wins over a plain drain in the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_owner <= OWNER_A;
        end else if (ack_own) begin
            out_valid <= 1'b1;
            out_data  <= mux_f;
            out_owner <= ack_b ? OWNER_B : OWNER_A;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux8bit_arbiter.sv
// Bench for mux8bit_arbiter: two instances (hold limit 4 and 1) driven by
// protocol-respecting random requesters and compared against a grant-streak model.
module tb_mux8bit_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req_a[2], req_b[2], out_ready[2];
    logic [7:0] data_a[2], data_b[2];
    logic       ack_a[2], ack_b[2], sel[2], out_valid[2], out_owner[2];
    logic [7:0] out_data[2];

    mux8bit_arbiter #(.MAX_HOLD(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a[0]), .data_a(data_a[0]), .ack_a(ack_a[0]),
        .req_b(req_b[0]), .data_b(data_b[0]), .ack_b(ack_b[0]),
        .sel(sel[0]), .out_valid(out_valid[0]), .out_data(out_data[0]),
        .out_owner(out_owner[0]), .out_ready(out_ready[0])
    );

    mux8bit_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a[1]), .data_a(data_a[1]), .ack_a(ack_a[1]),
        .req_b(req_b[1]), .data_b(data_b[1]), .ack_b(ack_b[1]),
        .sel(sel[1]), .out_valid(out_valid[1]), .out_data(out_data[1]),
        .out_owner(out_owner[1]), .out_ready(out_ready[1])
    );

    // Model: owner is -1 when nobody holds the path; streak counts grants
    // given to the owner while the other side was waiting.
    int         hold_lim[2] = '{4, 1};
    int         m_owner[2], m_last[2], m_streak[2];
    logic       m_v[2], m_o[2];
    logic [7:0] m_d[2];

    logic       n_ra[2], n_rb[2], n_rd[2];
    logic [7:0] n_da[2], n_db[2];
    int         pa, pb, pr;

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, k, cycle, obs, exp);
        end
    endtask

    task automatic model_reset(input int k);
        m_owner[k]  = -1;
        m_last[k]   = 1;
        m_streak[k] = 0;
        m_v[k]      = 1'b0;
        m_d[k]      = 8'h00;
        m_o[k]      = 1'b0;
    endtask

    function automatic logic exp_ack(input int k, input int x);
        logic r;
        r = (x == 1) ? req_b[k] : req_a[k];
        return (m_owner[k] == x) && r && (!m_v[k] || out_ready[k]);
    endfunction

    task automatic check_cycle(input int k);
        chk("ack_a",     k, 8'(ack_a[k]),     8'(exp_ack(k, 0)));
        chk("ack_b",     k, 8'(ack_b[k]),     8'(exp_ack(k, 1)));
        chk("sel",       k, 8'(sel[k]),       8'(m_owner[k] == 1));
        chk("out_valid", k, 8'(out_valid[k]), 8'(m_v[k]));
        chk("out_data",  k, out_data[k],      m_d[k]);
        chk("out_owner", k, 8'(out_owner[k]), 8'(m_o[k]));
    endtask

    task automatic plan_next(input int k);
        if (req_a[k] && !exp_ack(k, 0)) begin
            n_ra[k] = req_a[k];
            n_da[k] = data_a[k];
        end else begin
            n_ra[k] = int'($urandom_range(99)) < pa;
            n_da[k] = 8'($urandom);
        end
        if (req_b[k] && !exp_ack(k, 1)) begin
            n_rb[k] = req_b[k];
            n_db[k] = data_b[k];
        end else begin
            n_rb[k] = int'($urandom_range(99)) < pb;
            n_db[k] = 8'($urandom);
        end
        n_rd[k] = int'($urandom_range(99)) < pr;
    endtask

    task automatic model_step(input int k);
        logic ea, eb;
        logic r[2];
        int   x, y;
        ea = exp_ack(k, 0);
        eb = exp_ack(k, 1);
        if (ea) begin
            m_v[k] = 1'b1; m_d[k] = data_a[k]; m_o[k] = 1'b0;
        end else if (eb) begin
            m_v[k] = 1'b1; m_d[k] = data_b[k]; m_o[k] = 1'b1;
        end else if (out_ready[k]) begin
            m_v[k] = 1'b0;
        end
        r[0] = req_a[k];
        r[1] = req_b[k];
        if (m_owner[k] < 0) begin
            if (r[0] && r[1])  m_owner[k] = (m_last[k] == 1) ? 0 : 1;
            else if (r[0])     m_owner[k] = 0;
            else if (r[1])     m_owner[k] = 1;
        end else begin
            x = m_owner[k];
            y = 1 - x;
            if (!r[x]) begin
                m_last[k]   = x;
                m_streak[k] = 0;
                m_owner[k]  = r[y] ? y : -1;
            end else if (ea || eb) begin
                if (r[y]) begin
                    m_streak[k]++;
                    if (m_streak[k] == hold_lim[k]) begin
                        m_owner[k]  = y;
                        m_streak[k] = 0;
                        m_last[k]   = x;
                    end
                end else begin
                    m_streak[k] = 0;
                end
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check_cycle(k);
            plan_next(k);
            model_step(k);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            req_a[k]     = n_ra[k];
            data_a[k]    = n_da[k];
            req_b[k]     = n_rb[k];
            data_b[k]    = n_db[k];
            out_ready[k] = n_rd[k];
        end
        cycle++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_a[k] = 1'b0; req_b[k] = 1'b0; out_ready[k] = 1'b1;
            data_a[k] = 8'h00; data_b[k] = 8'h00;
            model_reset(k);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) check_cycle(k);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single requester A with byte 5A
        for (int k = 0; k < 2; k++) begin
            req_a[k] = 1'b1;
            data_a[k] = 8'h5A;
        end
        pa = 100; pb = 0; pr = 100;
        run(2);
        chk("single_data",  0, out_data[0],      8'h5A);
        chk("single_owner", 0, 8'(out_owner[0]), 8'h00);
        chk("single_valid", 0, 8'(out_valid[0]), 8'h01);
        run(2);
        pa = 0;
        run(3);

        // Contention, backpressure, owner drop
        pa = 100; pb = 100; pr = 100;
        run(14);
        pr = 0;
        run(4);
        pr = 100;
        run(4);
        pa = 0;
        run(4);
        pa = 100;
        run(5);

        // Reset while a byte is held
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_valid", k, 8'(out_valid[k]), 8'h00);
            chk("rst_sel",   k, 8'(sel[k]),       8'h00);
            chk("rst_ack_a", k, 8'(ack_a[k]),     8'h00);
            chk("rst_ack_b", k, 8'(ack_b[k]),     8'h00);
            chk("rst_data",  k, out_data[k],      8'h00);
            model_reset(k);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(6);

        // Randomised traffic
        pa = 60; pb = 60; pr = 70;
        run(300);
        pa = 90; pb = 90; pr = 90;
        run(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
